alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of requesters sharing one ALU (2..4 supported).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid  input  NREQ  per-requester operation request.
REQ-005 req_ready  output  NREQ  per-requester accept; request i is accepted in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-006 req_op  input  NREQ x 4  per-requester ALU opcode: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 unsigned less-than, 6 unsigned greater-than.
REQ-007 req_a, req_b  input  NREQ x 32 each  per-requester operands.
REQ-008 rsp_valid  output  NREQ  per-requester result available.
REQ-009 rsp_ready  input  NREQ  per-requester result consumed; handshake completes when rsp_valid[i] and rsp_ready[i] are both 1.
REQ-010 rsp_result  output  32  result, shared by all requesters, qualified by rsp_valid.
REQ-011 rsp_zero  output  1  1 when rsp_result == 0.
REQ-012 rsp_err  output  1  1 when the accepted opcode was 7..15.

Function
REQ-013 FSM states: IDLE, EXEC, RESP; exactly one operation in flight at any time.
REQ-014 IDLE: if any req_valid is 1, grant exactly one requester, assert only its req_ready, capture its op/a/b, go to EXEC; otherwise stay in IDLE.
REQ-015 req_ready is 0 in EXEC and RESP and is never asserted for a requester whose req_valid is 0.
REQ-016 Arbitration round-robin: search starts at (last_grant+1) mod NREQ; the first requester with req_valid=1 wins.
REQ-017 last_grant updates only on an accepted request.
REQ-018 EXEC: drive the captured operands into the ALU, register result, zero and err; go to RESP; takes exactly one cycle.
REQ-019 RESP: rsp_valid asserted only for the granted requester; result, zero and err held stable until its handshake completes.
REQ-020 RESP with rsp_ready[granted]=1 -> IDLE next cycle; with 0 -> remain in RESP indefinitely (backpressure).
REQ-021 Latency: request accepted at cycle T gives rsp_valid at T+2; minimum 3 cycles between consecutive accepts.
REQ-022 Opcodes 7..15: rsp_result=0, rsp_zero=1, rsp_err=1; the ALU output is ignored.
REQ-023 Arithmetic 32-bit modulo 2^32; sub wraps (0-1 = 0xFFFFFFFF); compares unsigned, result 0 or 1.
REQ-024 rsp_ready asserted for a non-granted requester, or while rsp_valid is 0, has no effect.
REQ-025 Input changes while req_ready=0 have no effect; operands are sampled only on the accept cycle.

Reset
REQ-026 rst=1 at a rising edge -> state IDLE, last_grant=NREQ-1 (requester 0 first), rsp_valid=0, req_ready=0, rsp_result=0, rsp_zero=0, rsp_err=0.
REQ-027 Reset during EXEC or RESP abandons the in-flight operation without producing a response.
REQ-028 req_ready is 0 in any cycle in which rst=1.

Structure
REQ-029 FSM state enum and opcode constants (OP_ADD..OP_GT, OP_MAX=6) belong in the shared core package, also used by decode.
REQ-030 A single sub-module instance: the existing combinational alu, fed from the captured operand registers.

Verification
REQ-031 Single: req_valid=01, op=0, a=5, b=7 at T -> rsp_valid=01 at T+2, result=12, zero=0, err=0.
REQ-032 Contention: req_valid=11 held, rsp_ready=11 -> grants alternate 0,1,0,1; each requester receives its own results in order.
REQ-033 Wrap/compare: op=1, a=0, b=1 -> 0xFFFFFFFF; op=5, a=3, b=0xFFFFFFFF -> 1; op=4, a=b=0xA5A5A5A5 -> 0, zero=1.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and result held stable, req_ready=0 throughout; accepts resume after the handshake.
REQ-035 Illegal op=9 -> result=0, zero=1, err=1; the next legal op clears err.
REQ-036 rst asserted in EXEC -> next cycle IDLE, rsp_valid=0, no response delivered; next grant goes to requester 0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter_pkg
//  Brief    : Shared constants for the ALU arbiter: FSM state encoding,
//             opcode values and datapath widths.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    // Arbiter FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // ALU opcodes; everything above OP_MAX is reported as an error
    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR = 4'd4;
    localparam logic [OP_W-1:0] OP_LT  = 4'd5;
    localparam logic [OP_W-1:0] OP_GT  = 4'd6;
    localparam logic [OP_W-1:0] OP_MAX = 4'd6;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op <= OP_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter_alu
//  Brief    : Purely combinational 32-bit ALU. Unsigned compares return 0/1;
//             unknown opcodes yield zero (the caller flags them separately).
//  Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    // Opcode decode into the selected arithmetic/logic function
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_LT:   result = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_GT:   result = {{(DATA_W-1){1'b0}}, (a > b)};
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Brief    : Round-robin arbiter sharing one ALU between NREQ requesters.
//             One operation in flight: IDLE (grant) -> EXEC (compute) ->
//             RESP (hold result until the granted requester consumes it).
//  Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ-1:0][OP_W-1:0]    req_op,
    input  logic [NREQ-1:0][DATA_W-1:0]  req_a,
    input  logic [NREQ-1:0][DATA_W-1:0]  req_b,
    output logic [NREQ-1:0]              rsp_valid,
    input  logic [NREQ-1:0]              rsp_ready,
    output logic [DATA_W-1:0]            rsp_result,
    output logic                         rsp_zero,
    output logic                         rsp_err
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // One extra bit so last_grant + offset never overflows before the wrap
    localparam int IW = GW + 1;

    state_t              r_state;
    state_t              w_next_state;
    logic [GW-1:0]       r_last_grant;
    logic [GW-1:0]       r_grant;
    logic [OP_W-1:0]     r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_result;
    logic                r_zero;
    logic                r_err;
    logic [DATA_W-1:0]   w_alu_result;
    logic                w_found;
    logic [GW-1:0]       w_pick;
    logic [IW-1:0]       w_idx;
    logic                w_accept;
    logic                w_rsp_done;

    alu_arbiter_alu u_alu (
        .op     (r_op),
        .a      (r_a),
        .b      (r_b),
        .result (w_alu_result)
    );

    // Round-robin search starting just after the last granted requester
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = {1'b0, r_last_grant} + IW'(k);
            if (w_idx >= IW'(NREQ)) begin
                w_idx = w_idx - IW'(NREQ);
            end
            if (!w_found && req_valid[w_idx[GW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[GW-1:0];
            end
        end
    end

    assign w_accept   = (r_state == ST_IDLE) && w_found && !rst;
    assign w_rsp_done = (r_state == ST_RESP) && rsp_ready[r_grant];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_found) w_next_state = ST_EXEC;
            ST_EXEC: w_next_state = ST_RESP;
            ST_RESP: if (w_rsp_done) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: one-hot accept in IDLE, one-hot response in RESP
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (w_accept) begin
            req_ready[w_pick] = 1'b1;
        end
        if (r_state == ST_RESP) begin
            rsp_valid[r_grant] = 1'b1;
        end
    end

    // Operand capture on accept and result registration in EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= GW'(NREQ - 1);
            r_grant      <= '0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_pick;
                r_grant      <= w_pick;
                r_op         <= req_op[w_pick];
                r_a          <= req_a[w_pick];
                r_b          <= req_b[w_pick];
            end
            if (r_state == ST_EXEC) begin
                if (op_is_legal(r_op)) begin
                    r_result <= w_alu_result;
                    r_zero   <= (w_alu_result == '0);
                    r_err    <= 1'b0;
                end else begin
                    r_result <= '0;
                    r_zero   <= 1'b1;
                    r_err    <= 1'b1;
                end
            end
        end
    end

    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Brief    : Self-checking bench for alu_arbiter (NREQ=2) against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][3:0]  req_op;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_zero;
    logic             rsp_err;

    int vectors     = 0;
    int miscompares = 0;
    int m_last      = 1;

    alu_arbiter #(.NREQ(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    // Reference: {err, result} from the opcode table
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return {1'b0, a + b};
            4'd1:    return {1'b0, a - b};
            4'd2:    return {1'b0, a & b};
            4'd3:    return {1'b0, a | b};
            4'd4:    return {1'b0, a ^ b};
            4'd5:    return {1'b0, (a < b) ? 32'd1 : 32'd0};
            4'd6:    return {1'b0, (a > b) ? 32'd1 : 32'd0};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from requester r alone and collect its response
    task automatic run_one(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [1:0] rv, output logic [31:0] res,
                           output logic z, output logic e, output bit to);
        int n;
        to = 1'b0; lat = 0; rv = '0; res = '0; z = 1'b0; e = 1'b0;
        rsp_ready = 2'b11;
        req_valid = 2'b01 << r;
        req_op[r] = op; req_a[r] = a; req_b[r] = b;
        #1;
        n = 0;
        while (!req_ready[r] && n < 20) begin tick(); n++; end
        if (n == 20) begin to = 1'b1; req_valid = '0; #1; return; end
        tick();
        req_valid = '0;
        req_a[r] = $urandom; req_b[r] = $urandom; req_op[r] = 4'($urandom_range(0, 15));
        #1;
        lat = 1;
        while (rsp_valid == 2'b00 && lat < 20) begin tick(); lat++; end
        if (lat == 20) begin to = 1'b1; return; end
        rv = rsp_valid; res = rsp_result; z = rsp_zero; e = rsp_err;
        tick();
        m_last = r;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
        req_op = '0; req_a = '0; req_b = '0;
        tick(); tick();
        vectors++;
        if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
        vectors++;
        if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
        vectors++;
        if ({rsp_result, rsp_zero, rsp_err} !== 34'd0) begin
            miscompares++; $display("FAIL reset_outputs: got result=%h zero=%b err=%b expected 0/0/0", rsp_result, rsp_zero, rsp_err);
        end
        rst = 1'b0; #1;
        vectors++;
        if (req_ready !== 2'b01) begin miscompares++; $display("FAIL reset_first_grant: got %b expected 01", req_ready); end
        req_valid = 2'b00; #1;
        m_last = 1;
    endtask

    task automatic test_single();
        int lat; logic [1:0] rv; logic [31:0] res; logic z, e; bit to;
        run_one(0, 4'd0, 32'd5, 32'd7, lat, rv, res, z, e, to);
        vectors++;
        if (to || lat != 2) begin miscompares++; $display("FAIL single_latency: got %0d (timeout=%0d) expected 2", lat, to); end
        vectors++;
        if (rv !== 2'b01) begin miscompares++; $display("FAIL single_rsp_valid: got %b expected 01", rv); end
        vectors++;
        if ({res, z, e} !== {32'd12, 1'b0, 1'b0}) begin
            miscompares++; $display("FAIL single_result: got %h z=%b e=%b expected 0000000c z=0 e=0", res, z, e);
        end
    endtask

    task automatic test_ops();
        logic [3:0]  t_op [8] = '{4'd1, 4'd5, 4'd4, 4'd0, 4'd6, 4'd6, 4'd2, 4'd3};
        logic [31:0] t_a  [8] = '{32'h0, 32'h3, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hF0F0F0F0, 32'hF0000000};
        logic [31:0] t_b  [8] = '{32'h1, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h0FF00FF0, 32'h0000000F};
        logic [31:0] t_r  [8] = '{32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h1, 32'h0, 32'h00F000F0, 32'hF000000F};
        int lat; logic [1:0] rv; logic [31:0] res, er; logic z, e, ee; bit to;
        logic [3:0] op; logic [31:0] a, b; logic [32:0] m; int r;
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 1);
            if (i < 8) begin
                op = t_op[i]; a = t_a[i]; b = t_b[i]; er = t_r[i]; ee = 1'b0;
            end else begin
                op = 4'($urandom_range(0, 6)); a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                m = ref_alu(op, a, b); er = m[31:0]; ee = m[32];
            end
            run_one(r, op, a, b, lat, rv, res, z, e, to);
            vectors++;
            if (to || lat != 2 || rv !== (2'b01 << r)) begin
                miscompares++; $display("FAIL ops_handshake[%0d]: got lat=%0d rv=%b to=%0d expected lat=2 rv=%b", i, lat, rv, to, 2'b01 << r);
            end
            vectors++;
            if ({res, z, e} !== {er, (er == 32'd0), ee}) begin
                miscompares++; $display("FAIL ops_result[%0d] op=%0d a=%h b=%h: got %h z=%b e=%b expected %h z=%b e=%b",
                                        i, op, a, b, res, z, e, er, (er == 32'd0), ee);
            end
        end
    endtask

    task automatic test_illegal();
        int lat; logic [1:0] rv; logic [31:0] res; logic z, e; bit to;
        run_one(0, 4'd9, $urandom, $urandom, lat, rv, res, z, e, to);
        vectors++;
        if (to || {res, z, e} !== {32'd0, 1'b1, 1'b1}) begin
            miscompares++; $display("FAIL illegal_op: got %h z=%b e=%b expected 00000000 z=1 e=1", res, z, e);
        end
        run_one(1, 4'd0, 32'd1, 32'd2, lat, rv, res, z, e, to);
        vectors++;
        if (to || {res, z, e} !== {32'd3, 1'b0, 1'b0}) begin
            miscompares++; $display("FAIL illegal_clear: got %h z=%b e=%b expected 00000003 z=0 e=0", res, z, e);
        end
    endtask

    task automatic test_contention();
        logic [31:0] q0[$];
        logic [31:0] q1[$];
        logic [32:0] m;
        logic [31:0] ex;
        int exp_g, accepts, since, gi, n;
        rsp_ready = 2'b11;
        for (int r = 0; r < 2; r++) begin
            req_op[r] = 4'($urandom_range(0, 6)); req_a[r] = $urandom; req_b[r] = $urandom;
        end
        req_valid = 2'b11;
        #1;
        exp_g = (m_last + 1) % 2; accepts = 0; since = 3; n = 0;
        while (n < 200 && (accepts < 12 || q0.size() + q1.size() > 0)) begin
            gi = -1;
            if (req_ready != 2'b00) begin
                gi = req_ready[1] ? 1 : 0;
                vectors++;
                if (req_ready !== (2'b01 << exp_g)) begin
                    miscompares++; $display("FAIL contention_grant: got %b expected %b", req_ready, 2'b01 << exp_g);
                end
                vectors++;
                if (since < 3) begin miscompares++; $display("FAIL contention_spacing: got %0d cycles expected >= 3", since); end
                m = ref_alu(req_op[gi], req_a[gi], req_b[gi]);
                if (gi == 0) q0.push_back(m[31:0]); else q1.push_back(m[31:0]);
                m_last = gi; exp_g = 1 - gi; accepts++; since = 0;
            end
            if (rsp_valid != 2'b00) begin
                vectors++;
                if (rsp_valid === 2'b01 && q0.size() > 0) begin
                    ex = q0.pop_front();
                    if (rsp_result !== ex) begin miscompares++; $display("FAIL contention_result0: got %h expected %h", rsp_result, ex); end
                end else if (rsp_valid === 2'b10 && q1.size() > 0) begin
                    ex = q1.pop_front();
                    if (rsp_result !== ex) begin miscompares++; $display("FAIL contention_result1: got %h expected %h", rsp_result, ex); end
                end else begin
                    miscompares++; $display("FAIL contention_rsp: got rsp_valid=%b with no pending result for it", rsp_valid);
                end
            end
            tick(); n++; since++;
            if (gi >= 0) begin
                req_op[gi] = 4'($urandom_range(0, 6)); req_a[gi] = $urandom; req_b[gi] = $urandom;
            end
            if (accepts >= 12) req_valid = 2'b00;
            #1;
        end
        vectors++;
        if (accepts < 12 || q0.size() + q1.size() > 0) begin
            miscompares++; $display("FAIL contention_timeout: got %0d accepts, %0d pending expected 12, 0", accepts, q0.size() + q1.size());
        end
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, ex; int n;
        a = $urandom; b = $urandom; ex = a + b;
        rsp_ready = 2'b00;
        req_op[1] = 4'd0; req_a[1] = a; req_b[1] = b; req_valid = 2'b10;
        #1;
        n = 0;
        while (req_ready !== 2'b10 && n < 10) begin tick(); n++; end
        vectors++;
        if (n == 10) begin miscompares++; $display("FAIL bp_accept: got req_ready=%b expected 10", req_ready); end
        tick();
        req_valid = 2'b11; req_a[1] = ~a; req_op[1] = 4'd9;
        #1;
        tick();
        for (int c = 0; c < 5; c++) begin
            rsp_ready = 2'($urandom_range(0, 1));
            req_a[0] = $urandom;
            #1;
            vectors++;
            if (rsp_valid !== 2'b10) begin miscompares++; $display("FAIL bp_rsp_valid[%0d]: got %b expected 10", c, rsp_valid); end
            vectors++;
            if (rsp_result !== ex || rsp_err !== 1'b0) begin
                miscompares++; $display("FAIL bp_result[%0d]: got %h e=%b expected %h e=0", c, rsp_result, rsp_err, ex);
            end
            vectors++;
            if (req_ready !== 2'b00) begin miscompares++; $display("FAIL bp_req_ready[%0d]: got %b expected 00", c, req_ready); end
            tick();
        end
        rsp_ready = 2'b10;
        #1;
        vectors++;
        if (rsp_valid !== 2'b10 || rsp_result !== ex) begin
            miscompares++; $display("FAIL bp_final: got rv=%b %h expected rv=10 %h", rsp_valid, rsp_result, ex);
        end
        tick();
        vectors++;
        if (req_ready !== 2'b01) begin miscompares++; $display("FAIL bp_resume: got %b expected 01", req_ready); end
        req_valid = 2'b00;
        #1;
        m_last = 1;
    endtask

    task automatic test_reset_exec();
        rsp_ready = 2'b11;
        req_op[0] = 4'd0; req_a[0] = 32'd1; req_b[0] = 32'd1; req_valid = 2'b01;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rstx_accept: got %b expected 01", req_ready); end
        tick();
        rst = 1'b1; req_valid = 2'b11;
        #1;
        vectors++;
        if (req_ready !== 2'b00) begin miscompares++; $display("FAIL rstx_ready_in_reset: got %b expected 00", req_ready); end
        tick();
        rst = 1'b0; req_valid = 2'b00;
        #1;
        vectors++;
        if ({rsp_result, rsp_zero, rsp_err} !== 34'd0) begin
            miscompares++; $display("FAIL rstx_outputs: got %h z=%b e=%b expected 0/0/0", rsp_result, rsp_zero, rsp_err);
        end
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL rstx_no_rsp[%0d]: got %b expected 00", c, rsp_valid); end
            tick();
        end
        req_valid = 2'b11;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rstx_next_grant: got %b expected 01", req_ready); end
        req_valid = 2'b00;
        #1;
        m_last = 1;
    endtask

    task automatic test_random();
        bit busy; int age, g, last, pick, i;
        logic [31:0] er; logic ez, ee; logic [32:0] m;
        logic [1:0] exp_rdy, exp_rv;
        rst = 1'b1; req_valid = 2'b00;
        tick();
        rst = 1'b0; last = 1; busy = 1'b0; age = 0; g = 0; er = '0; ez = 1'b0; ee = 1'b0;
        for (int c = 0; c < 400; c++) begin
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = 2'($urandom_range(0, 3));
            for (int r = 0; r < 2; r++) begin
                req_op[r] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
                req_a[r]  = $urandom;
                req_b[r]  = ($urandom_range(0, 4) == 0) ? req_a[r] : $urandom;
            end
            #1;
            pick = -1;
            if (!busy) begin
                for (int k = 1; k <= 2; k++) begin
                    i = (last + k) % 2;
                    if (pick < 0 && req_valid[i]) pick = i;
                end
            end
            exp_rdy = (pick >= 0) ? (2'b01 << pick) : 2'b00;
            exp_rv  = (busy && age >= 2) ? (2'b01 << g) : 2'b00;
            vectors++;
            if (req_ready !== exp_rdy) begin miscompares++; $display("FAIL rand_req_ready[%0d]: got %b expected %b", c, req_ready, exp_rdy); end
            vectors++;
            if (rsp_valid !== exp_rv) begin miscompares++; $display("FAIL rand_rsp_valid[%0d]: got %b expected %b", c, rsp_valid, exp_rv); end
            if (exp_rv != 2'b00) begin
                vectors++;
                if ({rsp_result, rsp_zero, rsp_err} !== {er, ez, ee}) begin
                    miscompares++; $display("FAIL rand_result[%0d]: got %h z=%b e=%b expected %h z=%b e=%b",
                                            c, rsp_result, rsp_zero, rsp_err, er, ez, ee);
                end
            end
            if (pick >= 0) begin
                busy = 1'b1; age = 1; g = pick; last = pick;
                m = ref_alu(req_op[pick], req_a[pick], req_b[pick]);
                er = m[31:0]; ee = m[32]; ez = (m[31:0] == 32'd0);
            end else if (busy) begin
                if (age >= 2 && rsp_ready[g]) busy = 1'b0;
                else if (age < 2) age++;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; rsp_ready = '0;
        req_op = '0; req_a = '0; req_b = '0;
        test_reset();
        test_single();
        test_ops();
        test_illegal();
        test_contention();
        test_backpressure();
        test_reset_exec();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
